// File: rtl/interconn_pkg.sv
// Shared definitions for the MVU crossbar interconnect: transmit FSM state
// encoding and default geometry constants used by the crossbar, tx and rx sides.
package interconn_pkg;

    localparam int DEF_N     = 8;
    localparam int DEF_W     = 64;
    localparam int DEF_BADDR = 15;
    localparam int DEF_BLEN  = 15;
    localparam int DEF_RDLAT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/interconn_tx_pipe.sv
// Read-latency delay line for interconn_tx: carries a valid bit and the remote
// write address alongside each outstanding local memory read.
module interconn_tx_pipe #(
    parameter int DEPTH = 2,
    parameter int AW    = 15
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    output logic          out_valid,
    output logic [AW-1:0] out_addr,
    output logic          empty
);

    logic [DEPTH-1:0] vld;
    logic [AW-1:0]    adr [DEPTH];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            vld <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                adr[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            adr[0] <= in_addr;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                adr[i] <= adr[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_addr  = adr[DEPTH-1];
    assign empty     = ~|vld;

endmodule

// File: rtl/interconn_tx.sv
// Per-MVU crossbar transmit engine: streams a block of local memory words to a
// destination mask with incrementing remote addresses. Optional INTERCONN_TX_PAUSE_EN adds a read-pause input.
module interconn_tx
    import interconn_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int W     = DEF_W,
    parameter int BADDR = DEF_BADDR,
    parameter int BLEN  = DEF_BLEN,
    parameter int RDLAT = DEF_RDLAT
) (
    input  logic             clk,
    input  logic             clr_n,
`ifdef INTERCONN_TX_PAUSE_EN
    input  logic             pause,
`endif
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [N-1:0]     cmd_dest,
    input  logic [BADDR-1:0] cmd_src_addr,
    input  logic [BADDR-1:0] cmd_dst_addr,
    input  logic [BLEN-1:0]  cmd_len,
    output logic             mem_rd_en,
    output logic [BADDR-1:0] mem_rd_addr,
    input  logic [W-1:0]     mem_rd_word,
    output logic [N-1:0]     send_to,
    output logic             send_en,
    output logic [BADDR-1:0] send_addr,
    output logic [W-1:0]     send_word,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_READ  = READ;
    localparam logic [1:0] S_DRAIN = DRAIN;
    localparam logic [1:0] S_DONE  = DONE;

    logic [1:0]       state;
    logic [N-1:0]     dest_q;
    logic [BADDR-1:0] src_q;
    logic [BADDR-1:0] dst_q;
    logic [BLEN-1:0]  rem_q;

    logic             hold;
    logic             issue;
    logic             pipe_valid;
    logic [BADDR-1:0] pipe_addr;
    logic             pipe_empty;
    logic             last_send;

`ifdef INTERCONN_TX_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    assign issue     = (state == S_READ) && !hold;
    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign mem_rd_en   = issue;
    assign mem_rd_addr = src_q;

    // No reads are issued in DRAIN, so an empty delay line behind a valid
    // output word means that word is the final one of the transfer.
    assign last_send = (state == S_DRAIN) && send_en && pipe_empty;
    assign done      = (state == S_DONE) || last_send;

    interconn_tx_pipe #(
        .DEPTH (RDLAT),
        .AW    (BADDR)
    ) u_pipe (
        .clk       (clk),
        .clr_n     (clr_n),
        .in_valid  (issue),
        .in_addr   (dst_q),
        .out_valid (pipe_valid),
        .out_addr  (pipe_addr),
        .empty     (pipe_empty)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state  <= S_IDLE;
            dest_q <= '0;
            src_q  <= '0;
            dst_q  <= '0;
            rem_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        dest_q <= cmd_dest;
                        src_q  <= cmd_src_addr;
                        dst_q  <= cmd_dst_addr;
                        rem_q  <= cmd_len;
                        if (cmd_len == '0 || cmd_dest == '0) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (issue) begin
                        src_q <= src_q + BADDR'(1);
                        dst_q <= dst_q + BADDR'(1);
                        rem_q <= rem_q - BLEN'(1);
                        if (rem_q == BLEN'(1)) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (last_send) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            send_en   <= 1'b0;
            send_to   <= '0;
            send_addr <= '0;
            send_word <= '0;
        end else if (pipe_valid) begin
            send_en   <= 1'b1;
            send_to   <= dest_q;
            send_addr <= pipe_addr;
            send_word <= mem_rd_word;
        end else begin
            send_en   <= 1'b0;
            send_to   <= '0;
            send_addr <= '0;
            send_word <= '0;
        end
    end

endmodule

// File: tb/tb_interconn_tx.sv
// Directed self-checking bench for interconn_tx with a 2-cycle local memory
// model whose read word is a marker pattern OR'ed with the read address.
module tb_interconn_tx;

    localparam int RDLAT = 2;
    localparam logic [63:0] MARK = 64'hA5C3_0000_0000_0000;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        pause;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_dest;
    logic [14:0] cmd_src_addr;
    logic [14:0] cmd_dst_addr;
    logic [14:0] cmd_len;
    logic        mem_rd_en;
    logic [14:0] mem_rd_addr;
    logic [63:0] mem_rd_word;
    logic [7:0]  send_to;
    logic        send_en;
    logic [14:0] send_addr;
    logic [63:0] send_word;
    logic        busy;
    logic        done;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    interconn_tx #(
        .N     (8),
        .W     (64),
        .BADDR (15),
        .BLEN  (15),
        .RDLAT (RDLAT)
    ) dut (
        .clk          (clk),
        .clr_n        (clr_n),
`ifdef INTERCONN_TX_PAUSE_EN
        .pause        (pause),
`endif
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_dest     (cmd_dest),
        .cmd_src_addr (cmd_src_addr),
        .cmd_dst_addr (cmd_dst_addr),
        .cmd_len      (cmd_len),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_word  (mem_rd_word),
        .send_to      (send_to),
        .send_en      (send_en),
        .send_addr    (send_addr),
        .send_word    (send_word),
        .busy         (busy),
        .done         (done)
    );

    // Two-stage memory: word for a read in cycle c is visible in cycle c+2.
    logic [63:0] rd_d1;
    always @(posedge clk) begin
        rd_d1       <= mem_rd_en ? (MARK | 64'(mem_rd_addr)) : 64'h0;
        mem_rd_word <= rd_d1;
    end

    task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s@%0d: got %h expected %h", tag, k, obs, exp);
    endtask

    task automatic chk_cycle(input int k, input logic e_rd, input logic [14:0] e_rda,
                             input logic e_snd, input logic [7:0] e_to, input logic [14:0] e_sa,
                             input logic [63:0] e_sw, input logic e_done, input logic e_rdy);
        chk("rd_en", k, 64'(mem_rd_en), 64'(e_rd));
        if (e_rd) chk("rd_addr", k, 64'(mem_rd_addr), 64'(e_rda));
        chk("send_en", k, 64'(send_en), 64'(e_snd));
        chk("send_to", k, 64'(send_to), 64'(e_to));
        chk("send_addr", k, 64'(send_addr), 64'(e_sa));
        chk("send_word", k, send_word, e_sw);
        chk("done", k, 64'(done), 64'(e_done));
        chk("cmd_ready", k, 64'(cmd_ready), 64'(e_rdy));
        chk("busy", k, 64'(busy), 64'(!e_rdy));
    endtask

    // Starts at a negedge in IDLE (cycle 0), ends at negedge of the cycle
    // where cmd_ready is back, which can serve as the next cycle 0.
    task automatic run_xfer(input logic [7:0] dest, input logic [14:0] src,
                            input logic [14:0] dst, input logic [14:0] len);
        bit          empty_x;
        int          last;
        logic        e_rd, e_snd;
        logic [14:0] e_rda, e_sa;
        logic [63:0] e_sw;
        logic [7:0]  e_to;
        empty_x = (len == 0) || (dest == 0);
        last    = empty_x ? 1 : int'(len) + RDLAT + 1;
        chk("ready_c0", 0, 64'(cmd_ready), 64'h1);
        cmd_valid    = 1'b1;
        cmd_dest     = dest;
        cmd_src_addr = src;
        cmd_dst_addr = dst;
        cmd_len      = len;
        for (int k = 1; k <= last + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                cmd_valid    = 1'b0;
                cmd_dest     = ~dest;
                cmd_src_addr = 15'h5555;
                cmd_dst_addr = 15'h2AAA;
                cmd_len      = 15'd3;
            end
            e_rd  = !empty_x && k >= 1 && k <= int'(len);
            e_rda = src + 15'(k - 1);
            e_snd = !empty_x && k >= RDLAT + 2 && k <= last;
            e_sa  = e_snd ? dst + 15'(k - RDLAT - 2) : 15'h0;
            e_to  = e_snd ? dest : 8'h0;
            e_sw  = e_snd ? (MARK | 64'(15'(src + 15'(k - RDLAT - 2)))) : 64'h0;
            chk_cycle(k, e_rd, e_rda, e_snd, e_to, e_sa, e_sw, k == last, k == last + 1);
        end
    endtask

    initial begin
        clr_n = 1'b0; pause = 1'b0; cmd_valid = 1'b0;
        cmd_dest = '0; cmd_src_addr = '0; cmd_dst_addr = '0; cmd_len = '0;
        repeat (3) @(negedge clk);
        chk_cycle(-1, 1'b0, 15'h0, 1'b0, 8'h0, 15'h0, 64'h0, 1'b0, 1'b1);
        chk("rd_addr_rst", -1, 64'(mem_rd_addr), 64'h0);
        clr_n = 1'b1;
        @(negedge clk);

        // Main example: remote address wraps 0x7FFF -> 0x0000.
        run_xfer(8'b0000_0101, 15'h010, 15'h7FFE, 15'd4);
        // Empty-transfer paths.
        run_xfer(8'h05, 15'h040, 15'h050, 15'd0);
        run_xfer(8'h00, 15'h040, 15'h050, 15'd3);
        run_xfer(8'h80, 15'h7FFF, 15'h0001, 15'd1);

        // Back-to-back with cmd_valid held; fields change mid-transfer.
        cmd_valid = 1'b1; cmd_dest = 8'h02; cmd_src_addr = 15'h100;
        cmd_dst_addr = 15'h200; cmd_len = 15'd1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                cmd_dest = 8'h80; cmd_src_addr = 15'h300; cmd_dst_addr = 15'h400;
            end
            if (k == 6) cmd_valid = 1'b0;
            chk_cycle(k, k == 1 || k == 6, (k == 1) ? 15'h100 : 15'h300,
                      k == 4 || k == 9,
                      (k == 4) ? 8'h02 : (k == 9) ? 8'h80 : 8'h00,
                      (k == 4) ? 15'h200 : (k == 9) ? 15'h400 : 15'h0,
                      (k == 4) ? (MARK | 64'h100) : (k == 9) ? (MARK | 64'h300) : 64'h0,
                      k == 4 || k == 9, k == 5 || k == 10);
        end

        // Asynchronous reset during cycle 3 of a len=8 transfer.
        cmd_valid = 1'b1; cmd_dest = 8'hFF; cmd_src_addr = 15'h020;
        cmd_dst_addr = 15'h030; cmd_len = 15'd8;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            chk("abort_rd_en", k, 64'(mem_rd_en), 64'h1);
            chk("abort_rd_addr", k, 64'(mem_rd_addr), 64'(15'h020 + 15'(k - 1)));
        end
        clr_n = 1'b0;
        #1;
        chk_cycle(3, 1'b0, 15'h0, 1'b0, 8'h0, 15'h0, 64'h0, 1'b0, 1'b1);
        @(negedge clk);
        clr_n = 1'b1;
        for (int k = 4; k <= 14; k++) begin
            @(negedge clk);
            chk_cycle(k, 1'b0, 15'h0, 1'b0, 8'h0, 15'h0, 64'h0, 1'b0, 1'b1);
        end

        // Scoreboard runs near the top of the source address space.
        for (int i = 0; i < 3; i++) begin
            run_xfer(8'($urandom_range(1, 255)), 15'(15'h7FF0 + $urandom_range(0, 15)),
                     15'($urandom_range(0, 32767)), 15'($urandom_range(1, 64)));
        end

`ifdef INTERCONN_TX_PAUSE_EN
        // pause high in cycles 2-4: reads at 1 and 5..7, sends at 4 and 8..10.
        cmd_valid = 1'b1; cmd_dest = 8'h05; cmd_src_addr = 15'h010;
        cmd_dst_addr = 15'h7FFE; cmd_len = 15'd4;
        for (int k = 1; k <= 11; k++) begin
            logic [14:0] rda, sa;
            logic        snd;
            int          sidx;
            @(negedge clk);
            cmd_valid = 1'b0;
            pause = (k >= 2 && k <= 4);
            #1;
            rda  = (k == 1) ? 15'h010 : 15'(15'h010 + 15'(k - 4));
            snd  = (k == 4) || (k >= 8 && k <= 10);
            sidx = (k == 4) ? 0 : k - 7;
            sa   = snd ? 15'(15'h7FFE + 15'(sidx)) : 15'h0;
            chk_cycle(k, k == 1 || (k >= 5 && k <= 7), rda, snd, snd ? 8'h05 : 8'h00, sa,
                      snd ? (MARK | 64'(15'h010 + 15'(sidx))) : 64'h0, k == 10, k == 11);
        end
        pause = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/interconn_tx.md
Name: interconn_tx

Overview:
Per-MVU transmit engine driving one sender slot of the MVU crossbar interconnect: send_to, send_en, send_addr and send_word.
- Accepts a block-copy command through a valid/ready handshake.
- Streams the command's words out of the local MVU memory, accounting for the fixed memory read latency.
- Presents one word per cycle to the crossbar, each tagged with a destination mask and an incrementing remote write address.
- Pulses done when the last word has been sent.

Parameters:
N, 8, number of MVUs (width of destination mask)
W, 64, data word width
BADDR, 15, local and remote memory address width
BLEN, 15, transfer length field width (words)
RDLAT, 2, local memory read latency in cycles (>=1)

Ports:
clk  in  1  clock
clr_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  engine can accept a command
cmd_dest  in  N  destination MVU mask (bit j = MVU j)
cmd_src_addr  in  BADDR  first local read address
cmd_dst_addr  in  BADDR  first remote write address
cmd_len  in  BLEN  number of words to transfer
mem_rd_en  out  1  local memory read strobe
mem_rd_addr  out  BADDR  local memory read address
mem_rd_word  in  W  read data, valid RDLAT cycles after mem_rd_en
send_to  out  N  destination mask to crossbar
send_en  out  1  word valid to crossbar
send_addr  out  BADDR  remote write address
send_word  out  W  data to crossbar
busy  out  1  transfer in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (clr_n low, asynchronous): every output is 0 except cmd_ready, which is 1. State is IDLE, the pipeline is flushed and counters are cleared. Reset mid-transfer aborts the transfer; in-flight reads are discarded and no send_en or done follows.
- FSM states: IDLE, READ, DRAIN, DONE.
  - cmd_ready = (state==IDLE).
  - busy = (state!=IDLE).
- IDLE: on cmd_valid&cmd_ready, latch dest, src, dst and len.
  - If len==0 or dest==0, go to DONE.
  - Otherwise go to READ.
- READ: one read per cycle.
  - mem_rd_en=1, with mem_rd_addr = src + k for the k-th read, k = 0..len-1.
  - After len reads, go to DRAIN.
- Read pipeline: an RDLAT-deep delay line carries a valid bit and the remote address.
  - A read issued in cycle c returns mem_rd_word in cycle c+RDLAT.
  - That word is registered onto the send_* outputs in cycle c+RDLAT+1: send_en=1, send_to=dest, send_addr = dst + k, send_word = the read word.
- When send_en=0, send_to, send_addr and send_word are 0.
- DRAIN: wait until the delay line and the output register are empty.
  - done pulses in the same cycle as the last send_en.
  - Then go to IDLE; cmd_ready returns the following cycle.
- DONE (empty-transfer path only): done=1 for one cycle, then IDLE.
- Address arithmetic: both src and dst counters wrap modulo 2^BADDR; there is no error on wrap.
- No crossbar backpressure: one word per cycle, never duplicated or dropped.
- cmd_* inputs are ignored outside the IDLE handshake; changing them mid-transfer has no effect.
- Latency: cmd accepted in cycle 0 gives first read in cycle 1, first send_en in cycle RDLAT+2 and last send_en/done in cycle len+RDLAT+1.

Optional Feature:
INTERCONN_TX_PAUSE_EN
- With the macro: adds input port pause (1 bit).
  - While pause=1 in READ, no read is issued and the src/dst/remaining counters hold.
  - Reads already in flight still complete and send normally.
  - Deasserting pause resumes at the held address.
  - pause has no effect in other states.
- Without the macro: the port is absent and reads issue back-to-back every READ cycle.

Decomposition:
- Package interconn_pkg holds:
  - the FSM state enum (IDLE, READ, DRAIN, DONE);
  - default constants for N, W, BADDR, BLEN and RDLAT, shared with the crossbar and the receive side.
- One sub-module, interconn_tx_pipe: an RDLAT-deep valid+address delay line with asynchronous active-low clear and an empty flag.

Test Plan:
- RDLAT=2, len=4, src=0x010, dst=0x7FFE, dest=8'b00000101, cmd accepted in cycle 0 -> expected response:
  - mem_rd_en in cycles 1-4 with addr 0x010..0x013;
  - send_en in cycles 4-7 with send_addr 0x7FFE, 0x7FFF, 0x0000, 0x0001 and send_to=0x05;
  - done in cycle 7, cmd_ready=1 in cycle 8.
- len=0 or dest=0 -> no mem_rd_en and no send_en; done in cycle 1, cmd_ready in cycle 2.
- Back-to-back commands, with cmd_valid held high and len=1 each -> second accepted in the first cycle cmd_ready rises; words appear in order with no overlap.
- clr_n low during cycle 3 of a len=8 transfer -> all outputs 0 immediately and cmd_ready=1; no send_en or done afterwards until a new command.
- Compare against a scoreboard model: memory preloaded with word = address; random len 1..64 and src near 0x7FF0 -> each send_word equals the expected source address modulo 2^15.
- With INTERCONN_TX_PAUSE_EN: pause=1 for cycles 2-4 of a len=4 transfer -> reads at 0x010 in cycle 1 and 0x011..0x013 in cycles 5-7; last send_en and done in cycle 10.
